// File: rtl/fb_defs.sv
// Shared framebuffer definitions: screen geometry, command and state encodings,
// and the {y, x} address packing used by both the plot writer and the display reader.
package fb_defs;
    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int COORD_W = 10;
    localparam int COLOR_W = 4;
    localparam int ADDR_W  = 2 * COORD_W;
    localparam int ERR_W   = COORD_W + 2;

    localparam logic OP_LINE  = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_DRAW  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [COORD_W-1:0] y,
                                                    input logic [COORD_W-1:0] x);
        return {y, x};
    endfunction
endpackage

// File: rtl/line_stepper.sv
// Combinational Bresenham step: both axis decisions are taken from the same e2,
// so a diagonal move updates x, y and err together in one cycle.
module line_stepper
    import fb_defs::*;
(
    input  logic signed [ERR_W-1:0]   i_err,
    input  logic signed [ERR_W-1:0]   i_dx,
    input  logic signed [ERR_W-1:0]   i_dy,
    input  logic        [COORD_W-1:0] i_x,
    input  logic        [COORD_W-1:0] i_y,
    input  logic        [COORD_W-1:0] i_x1,
    input  logic        [COORD_W-1:0] i_y1,
    input  logic                      i_sx,
    input  logic                      i_sy,
    output logic signed [ERR_W-1:0]   o_err_next,
    output logic        [COORD_W-1:0] o_x_next,
    output logic        [COORD_W-1:0] o_y_next,
    output logic                      o_at_end
);
    logic signed [ERR_W:0]   w_e2;
    logic signed [ERR_W:0]   w_dx_ext;
    logic signed [ERR_W:0]   w_dy_ext;
    logic                    w_step_x;
    logic                    w_step_y;
    logic signed [ERR_W-1:0] w_add_x;
    logic signed [ERR_W-1:0] w_add_y;

    // e2 carries one extra bit so doubling err can never overflow
    assign w_e2     = {i_err, 1'b0};
    assign w_dx_ext = {i_dx[ERR_W-1], i_dx};
    assign w_dy_ext = {i_dy[ERR_W-1], i_dy};

    assign w_step_x = (w_e2 >= w_dy_ext);
    assign w_step_y = (w_e2 <= w_dx_ext);

    assign w_add_x    = w_step_x ? i_dy : '0;
    assign w_add_y    = w_step_y ? i_dx : '0;
    assign o_err_next = i_err + w_add_x + w_add_y;

    assign o_x_next = !w_step_x ? i_x : (i_sx ? i_x + COORD_W'(1) : i_x - COORD_W'(1));
    assign o_y_next = !w_step_y ? i_y : (i_sy ? i_y + COORD_W'(1) : i_y - COORD_W'(1));

    assign o_at_end = (i_x == i_x1) && (i_y == i_y1);
endmodule

// File: rtl/fb_plot_writer.sv
// Framebuffer write-port driver: turns LINE/CLEAR commands into one registered
// pixel write per clock; off-screen line pixels are stepped but not written.
module fb_plot_writer
    import fb_defs::*;
#(
    parameter int P_H_RES = H_RES,
    parameter int P_V_RES = V_RES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmdValid,
    output logic               cmdReady,
    input  logic               cmdOp,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COLOR_W-1:0] cmdColor,
    output logic [ADDR_W-1:0]  address,
    output logic [COLOR_W-1:0] color,
    output logic               writeEnable,
    output logic               busy,
    output logic               done
);
    state_t r_state;
    state_t w_state_next;

    logic        [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;
    logic        [COLOR_W-1:0] r_cmd_color;
    logic        [COORD_W-1:0] r_x, r_y;
    logic        [COORD_W-1:0] r_cx, r_cy;
    logic signed [ERR_W-1:0]   r_err, r_dx, r_dy;
    logic                      r_sx, r_sy;

    logic        [ADDR_W-1:0]  r_address;
    logic        [COLOR_W-1:0] r_color;
    logic                      r_we;
    logic                      r_done;

    logic                      w_accept;
    logic        [COORD_W-1:0] w_adx, w_ady;
    logic signed [ERR_W-1:0]   w_setup_dx, w_setup_dy;
    logic signed [ERR_W-1:0]   w_err_next;
    logic        [COORD_W-1:0] w_x_next, w_y_next;
    logic                      w_at_end;
    logic                      w_clear_last;
    logic                      w_on_screen;

    assign cmdReady = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign w_accept = cmdValid && cmdReady;

    assign w_adx      = (r_x0 < r_x1) ? (r_x1 - r_x0) : (r_x0 - r_x1);
    assign w_ady      = (r_y0 < r_y1) ? (r_y1 - r_y0) : (r_y0 - r_y1);
    assign w_setup_dx = $signed({{(ERR_W-COORD_W){1'b0}}, w_adx});
    assign w_setup_dy = -$signed({{(ERR_W-COORD_W){1'b0}}, w_ady});

    assign w_on_screen  = (r_x < COORD_W'(P_H_RES)) && (r_y < COORD_W'(P_V_RES));
    assign w_clear_last = (r_cx == COORD_W'(P_H_RES - 1)) && (r_cy == COORD_W'(P_V_RES - 1));

    line_stepper u_line_stepper (
        .i_err      (r_err),
        .i_dx       (r_dx),
        .i_dy       (r_dy),
        .i_x        (r_x),
        .i_y        (r_y),
        .i_x1       (r_x1),
        .i_y1       (r_y1),
        .i_sx       (r_sx),
        .i_sy       (r_sy),
        .o_err_next (w_err_next),
        .o_x_next   (w_x_next),
        .o_y_next   (w_y_next),
        .o_at_end   (w_at_end)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (cmdOp)
                        OP_LINE:  w_state_next = ST_SETUP;
                        OP_CLEAR: w_state_next = ST_CLEAR;
                        default:  w_state_next = ST_IDLE;
                    endcase
                end
            end
            ST_SETUP: w_state_next = ST_DRAW;
            ST_DRAW:  if (w_at_end) w_state_next = ST_DONE;
            ST_CLEAR: if (w_clear_last) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x0        <= '0;
            r_y0        <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_cmd_color <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_err       <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_sx        <= 1'b0;
            r_sy        <= 1'b0;
            r_address   <= '0;
            r_color     <= '0;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_we <= 1'b0;
                    if (w_accept) begin
                        r_x0        <= x0;
                        r_y0        <= y0;
                        r_x1        <= x1;
                        r_y1        <= y1;
                        r_cmd_color <= cmdColor;
                        r_cx        <= '0;
                        r_cy        <= '0;
                    end
                end
                ST_SETUP: begin
                    r_we  <= 1'b0;
                    r_dx  <= w_setup_dx;
                    r_dy  <= w_setup_dy;
                    r_sx  <= (r_x0 < r_x1);
                    r_sy  <= (r_y0 < r_y1);
                    r_err <= w_setup_dx + w_setup_dy;
                    r_x   <= r_x0;
                    r_y   <= r_y0;
                end
                ST_DRAW: begin
                    r_address <= pack_addr(r_y, r_x);
                    r_color   <= r_cmd_color;
                    r_we      <= w_on_screen;
                    r_err     <= w_err_next;
                    r_x       <= w_x_next;
                    r_y       <= w_y_next;
                end
                ST_CLEAR: begin
                    r_address <= pack_addr(r_cy, r_cx);
                    r_color   <= r_cmd_color;
                    r_we      <= 1'b1;
                    // raster order: wrap x at the right edge and advance the row
                    if (r_cx == COORD_W'(P_H_RES - 1)) begin
                        r_cx <= '0;
                        r_cy <= r_cy + COORD_W'(1);
                    end else begin
                        r_cx <= r_cx + COORD_W'(1);
                    end
                end
                ST_DONE: begin
                    r_we   <= 1'b0;
                    r_done <= 1'b1;
                end
                default: r_we <= 1'b0;
            endcase
        end
    end

    assign address     = r_address;
    assign color       = r_color;
    assign writeEnable = r_we;
    assign done        = r_done;
endmodule

// File: tb/tb_fb_plot_writer.sv
// Directed bench: line shapes, clipping, busy/abort handling on a full-size
// writer, and a full raster clear on a reduced-geometry instance.
module tb_fb_plot_writer;
    logic        clock = 1'b0;
    logic        reset;
    logic        cmdValid, cmdValid_s, cmdOp;
    logic [9:0]  x0, y0, x1, y1;
    logic [3:0]  cmdColor;

    logic        cmdReady, writeEnable, busy, done;
    logic [19:0] address;
    logic [3:0]  color;

    logic        cmdReady_s, writeEnable_s, busy_s, done_s;
    logic [19:0] address_s;
    logic [3:0]  color_s;

    int errors = 0;
    int checks = 0;

    logic [19:0] exp_addr[$];
    logic        exp_we[$];

    always #5 clock = ~clock;

    fb_plot_writer dut (
        .clock(clock), .reset(reset), .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdOp(cmdOp), .x0(x0), .y0(y0), .x1(x1), .y1(y1), .cmdColor(cmdColor),
        .address(address), .color(color), .writeEnable(writeEnable),
        .busy(busy), .done(done)
    );

    fb_plot_writer #(.P_H_RES(5), .P_V_RES(3)) dut_small (
        .clock(clock), .reset(reset), .cmdValid(cmdValid_s), .cmdReady(cmdReady_s),
        .cmdOp(cmdOp), .x0(x0), .y0(y0), .x1(x1), .y1(y1), .cmdColor(cmdColor),
        .address(address_s), .color(color_s), .writeEnable(writeEnable_s),
        .busy(busy_s), .done(done_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [19:0] a, input logic w);
        exp_addr.push_back(a);
        exp_we.push_back(w);
    endtask

    task automatic issue_line(input logic [9:0] ax0, input logic [9:0] ay0,
                              input logic [9:0] ax1, input logic [9:0] ay1,
                              input logic [3:0] col);
        x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; cmdColor = col;
        cmdOp = 1'b0;
        cmdValid = 1'b1;
        step();
        cmdValid = 1'b0;
        chk("accept_busy", 32'(busy), 32'd1);
    endtask

    // Called one cycle after the accepting edge; walks SETUP, the pixel run and DONE.
    task automatic run_check(input string tag, input logic [3:0] col);
        int n;
        n = exp_addr.size();
        step();
        chk({tag, "_setup_we"}, 32'(writeEnable), 32'd0);
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, "_addr"}, 32'(address), 32'(exp_addr[i]));
            chk({tag, "_we"}, 32'(writeEnable), 32'(exp_we[i]));
            chk({tag, "_color"}, 32'(color), 32'(col));
            chk({tag, "_ready_low"}, 32'(cmdReady), 32'd0);
        end
        step();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_done_we"}, 32'(writeEnable), 32'd0);
        chk({tag, "_done_ready"}, 32'(cmdReady), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        $display("line %s: %0d pixel cycles checked", tag, n);
        exp_addr.delete();
        exp_we.delete();
    endtask

    initial begin
        reset = 1'b1; cmdValid = 1'b0; cmdValid_s = 1'b0; cmdOp = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; cmdColor = '0;
        #1;
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_color", 32'(color), 32'd0);
        chk("rst_we", 32'(writeEnable), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmdReady), 32'd1);
        chk("rst_small_ready", 32'(cmdReady_s), 32'd1);
        #10 reset = 1'b0;
        step();

        issue_line(10'd0, 10'd0, 10'd3, 10'd0, 4'd9);
        push(20'd0, 1'b1); push(20'd1, 1'b1); push(20'd2, 1'b1); push(20'd3, 1'b1);
        run_check("horiz", 4'd9);

        issue_line(10'd0, 10'd0, 10'd2, 10'd2, 4'd3);
        push(20'h000, 1'b1); push(20'h401, 1'b1); push(20'h802, 1'b1);
        run_check("diag", 4'd3);

        issue_line(10'd5, 10'd10, 10'd4, 10'd7, 4'd6);
        push(20'h2805, 1'b1); push(20'h2405, 1'b1); push(20'h2004, 1'b1); push(20'h1C04, 1'b1);
        run_check("steep", 4'd6);

        issue_line(10'd638, 10'd0, 10'd641, 10'd0, 4'd5);
        push(20'd638, 1'b1); push(20'd639, 1'b1); push(20'd640, 1'b0); push(20'd641, 1'b0);
        run_check("clip", 4'd5);

        // cmdValid held high with new operands while the first line is in flight
        x0 = 10'd0; y0 = 10'd0; x1 = 10'd2; y1 = 10'd0; cmdColor = 4'd7; cmdOp = 1'b0;
        cmdValid = 1'b1;
        step();
        x0 = 10'd1; y0 = 10'd1; x1 = 10'd1; y1 = 10'd1; cmdColor = 4'd2;
        push(20'd0, 1'b1); push(20'd1, 1'b1); push(20'd2, 1'b1);
        run_check("held", 4'd7);
        chk("held_second_accept", 32'(busy), 32'd1);
        cmdValid = 1'b0;
        push(20'h401, 1'b1);
        run_check("zero_len", 4'd2);

        issue_line(10'd0, 10'd5, 10'd600, 10'd5, 4'd4);
        repeat (5) step();
        chk("abort_pre_we", 32'(writeEnable), 32'd1);
        chk("abort_pre_addr", 32'(address), 32'h1403);
        #3 reset = 1'b1;
        #1;
        chk("abort_we", 32'(writeEnable), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(cmdReady), 32'd1);
        chk("abort_address", 32'(address), 32'd0);
        chk("abort_color", 32'(color), 32'd0);
        #2 reset = 1'b0;
        step();
        issue_line(10'd0, 10'd0, 10'd2, 10'd2, 4'd11);
        push(20'h000, 1'b1); push(20'h401, 1'b1); push(20'h802, 1'b1);
        run_check("after_abort", 4'd11);

        // full raster clear on the 5x3 instance
        cmdOp = 1'b1; cmdColor = 4'd15; cmdValid_s = 1'b1;
        step();
        cmdValid_s = 1'b0;
        chk("clr_busy", 32'(busy_s), 32'd1);
        chk("clr_big_idle", 32'(busy), 32'd0);
        chk("clr_first_we", 32'(writeEnable_s), 32'd0);
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 5; x++) begin
                step();
                chk("clr_addr", 32'(address_s), 32'(y * 1024 + x));
                chk("clr_we", 32'(writeEnable_s), 32'd1);
                chk("clr_color", 32'(color_s), 32'd15);
            end
        end
        step();
        chk("clr_done", 32'(done_s), 32'd1);
        chk("clr_done_we", 32'(writeEnable_s), 32'd0);
        chk("clr_done_ready", 32'(cmdReady_s), 32'd1);
        step();
        chk("clr_done_pulse", 32'(done_s), 32'd0);
        $display("clear: 15 pixel cycles checked");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fb_plot_writer.md
# fb_plot_writer

Framebuffer writer for the graphing display: accepts draw commands (Bresenham line or full-screen clear) and emits one pixel write per clock into the write port of the display's dual-port framebuffer RAM. It sits between the plotting/control logic and the display controller. Its `address`/`color`/`writeEnable` outputs drive the RAM write side directly, while the display controller reads the same RAM continuously.

## Interface
- `H_RES`, 640: visible width; x ≥ H_RES is clipped.
- `V_RES`, 480: visible height; y ≥ V_RES is clipped.
- `COORD_W`, 10: coordinate width.
- `COLOR_W`, 4: palette index width (16-colour palette).

- `clock` in 1: single clock; same domain as the framebuffer write port (RAM writes on the opposite edge).
- `reset` in 1: asynchronous, active-high.
- `cmdValid` in 1: command offered.
- `cmdReady` out 1: high only in IDLE.
- `cmdOp` in 1: 0 = LINE, 1 = CLEAR.
- `x0`, `y0`, `x1`, `y1` in COORD_W each: line endpoints. Ignored for CLEAR.
- `cmdColor` in COLOR_W: palette index.
- `address` out 2*COORD_W: `{y, x}`. Must match the display read address packing `{pixelV, pixelH}`.
- `color` out COLOR_W: write data.
- `writeEnable` out 1: write strobe.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- **States:** IDLE, SETUP, DRAW, CLEAR, DONE.
- **IDLE:**
  - Accept on `cmdValid && cmdReady` at a rising edge.
  - Latch all command inputs; they are not sampled again.
  - Next state: SETUP for LINE, CLEAR for CLEAR.
- **SETUP (LINE only, one cycle):**
  - dx = |x1−x0|, dy = −|y1−y0|.
  - sx = +1 if x0 < x1, else −1; sy likewise for y.
  - err = dx + dy; (x, y) = (x0, y0).
  - Width rules: err is 12-bit signed and e2 = 2·err is 13-bit signed; all compares are signed.
- **DRAW (one pixel per cycle):**
  - Register `address` = {y, x} and `color`.
  - `writeEnable` = (x < H_RES && y < V_RES). Off-screen pixels are still stepped but not written.
  - If (x, y) == (x1, y1), go to DONE.
  - Otherwise step both conditions in the same cycle:
    - if e2 ≥ dy: err += dy, x += sx;
    - if e2 ≤ dx: err += dx, y += sy.
- **CLEAR:**
  - Raster sweep from x = 0, y = 0, one write per cycle, `writeEnable` = 1.
  - x wraps from H_RES−1 to 0 with y+1.
  - After writing {V_RES−1, H_RES−1}, go to DONE.
- **DONE:** `writeEnable` ← 0, `done` ← 1, next state IDLE.
- **Boundaries:**
  - Zero-length line (x0 == x1, y0 == y1): exactly one write.
  - `cmdValid` while busy: ignored (no queuing).
  - Reset mid-operation: immediate abort to IDLE with all outputs cleared. No partial-command resume.

## Timing
- **Reset values:**
  - `address` = 0, `color` = 0, `writeEnable` = 0, `done` = 0, `busy` = 0.
  - `cmdReady` = 1 (state IDLE).
- `cmdReady` and `busy` are decoded from state; all other outputs are registered.
- **LINE, accepted at edge 0:** N = max(dx, |dy|) + 1 pixels.
  - Edge 1: enter DRAW.
  - Edges 2…N+1: pixel writes, visible in the cycles following each edge, back-to-back with no gaps.
  - Edge N+2: `done` = 1 for one cycle, `writeEnable` = 0, `cmdReady` = 1 in that same cycle.
  - A new command may be accepted at edge N+3.
- **CLEAR, accepted at edge 0:**
  - Writes follow edges 1…H_RES·V_RES (307200 cycles).
  - `done` follows the next edge.
- Outputs are stable for a full cycle, so the RAM's opposite-edge write has half a period of setup.

## Structure
- Shared package/include `fb_defs`:
  - H_RES, V_RES, COORD_W, COLOR_W;
  - op encodings OP_LINE/OP_CLEAR;
  - state encodings;
  - address pack macro/function {y, x}.
- The display controller uses the same `fb_defs`.
- One sub-module, `line_stepper`: purely combinational Bresenham step (err, x, y, dx, dy, sx, sy in; next err/x/y and `atEnd` out). The top holds the FSM, CLEAR counters and output registers.

## Test plan
- **Horizontal line:** LINE (0,0)→(3,0), color 9 → addresses 0, 1, 2, 3 with color 9 on 4 consecutive cycles, then `done` pulse, `cmdReady` = 1.
- **Diagonal line:** LINE (0,0)→(2,2) → addresses 0x000, 0x401, 0x802; 3 writes.
- **Steep reversed line:** LINE (5,10)→(4,7) → pixels (5,10), (5,9), (4,8), (4,7), i.e. addresses 0x2805, 0x2405, 0x2004, 0x1C04.
- **Clipping:** LINE (638,0)→(641,0) → 4 DRAW cycles, `writeEnable` high only for x = 638, 639; `done` at edge 6 after accept.
- **Clear:** CLEAR color 15 → 307200 writes.
  - First address 0.
  - Address 1024 immediately follows 639.
  - Last address 491135 ({479,639}).
  - Then `done`.
- **Abort and busy handling:**
  - Assert `reset` during a long line: `writeEnable` drops asynchronously and the next command executes correctly.
  - `cmdValid` held during a busy LINE is not accepted until `cmdReady` returns.
